// File: rtl/mccu_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, MIPS opcode/func
// values, ALU operation codes, operand/PC select codes and the decoded instruction class.
package mccu_pkg;

    typedef enum logic [2:0] {
        SIF  = 3'd0,
        SID  = 3'd1,
        SEXE = 3'd2,
        SMEM = 3'd3,
        SWB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_RS   = 2'b10;
    localparam logic [1:0] PC_JUMP = 2'b11;

    // i_rtype flags the whole op = 0 group; the other fields are one-hot per instruction
    typedef struct packed {
        logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
        logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw;
        logic i_beq, i_bne, i_j, i_jal;
        logic i_rtype, i_undef;
    } iclass_t;

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction classifier: op/func -> one-hot instruction class.
// Any opcode, or R-type func, outside the supported subset is reported as i_undef.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        cls.i_rtype = (op == OP_RTYPE);
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  cls.i_add = 1'b1;
                    FN_SUB:  cls.i_sub = 1'b1;
                    FN_AND:  cls.i_and = 1'b1;
                    FN_OR:   cls.i_or  = 1'b1;
                    FN_XOR:  cls.i_xor = 1'b1;
                    FN_SLL:  cls.i_sll = 1'b1;
                    FN_SRL:  cls.i_srl = 1'b1;
                    FN_SRA:  cls.i_sra = 1'b1;
                    FN_JR:   cls.i_jr  = 1'b1;
                    default: cls.i_undef = 1'b1;
                endcase
            end
            OP_ADDI: cls.i_addi = 1'b1;
            OP_ANDI: cls.i_andi = 1'b1;
            OP_ORI:  cls.i_ori  = 1'b1;
            OP_XORI: cls.i_xori = 1'b1;
            OP_LUI:  cls.i_lui  = 1'b1;
            OP_LW:   cls.i_lw   = 1'b1;
            OP_SW:   cls.i_sw   = 1'b1;
            OP_BEQ:  cls.i_beq  = 1'b1;
            OP_BNE:  cls.i_bne  = 1'b1;
            OP_J:    cls.i_j    = 1'b1;
            OP_JAL:  cls.i_jal  = 1'b1;
            default: cls.i_undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/mccu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer sharing one ALU.
// Optional macro ILLEGAL_TRAP_EN makes undefined instructions trap in SID.
module mccu
    import mccu_pkg::*;
#(
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [5:0]    op,
    input  logic [5:0]    func,
    input  logic          z,
    output logic          wpc,
    output logic          wir,
    output logic          wmem,
    output logic          wreg,
    output logic          iord,
    output logic          regrt,
    output logic          m2reg,
    output logic [3:0]    aluc,
    output logic          shift,
    output logic          alusrca,
    output logic [1:0]    alusrcb,
    output logic          sext,
    output logic [1:0]    pcsource,
    output logic          jal,
    output logic [SW-1:0] state,
    output logic          illegal
);

    state_t     cur;
    state_t     nxt;
    iclass_t    cls;
    logic       wpc_d, wir_d, wmem_d, wreg_d;
    logic       r_alu, is_imm, wb_rt;
    logic [3:0] alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_d;
`endif

    mccu_decode u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    assign r_alu  = cls.i_rtype & ~cls.i_jr & ~cls.i_undef;
    assign is_imm = cls.i_addi | cls.i_andi | cls.i_ori | cls.i_xori | cls.i_lui | cls.i_lw | cls.i_sw;
    assign wb_rt  = cls.i_addi | cls.i_andi | cls.i_ori | cls.i_xori | cls.i_lui | cls.i_lw;

    always_comb begin
        if (cls.i_add | cls.i_addi | cls.i_lw | cls.i_sw) alu_op = ALU_ADD;
        else if (cls.i_sub)                               alu_op = ALU_SUB;
        else if (cls.i_and | cls.i_andi)                  alu_op = ALU_AND;
        else if (cls.i_or | cls.i_ori)                    alu_op = ALU_OR;
        else if (cls.i_xor | cls.i_xori)                  alu_op = ALU_XOR;
        else if (cls.i_lui)                               alu_op = ALU_LUI;
        else if (cls.i_sll)                               alu_op = ALU_SLL;
        else if (cls.i_srl)                               alu_op = ALU_SRL;
        else if (cls.i_sra)                               alu_op = ALU_SRA;
        else                                              alu_op = ALU_ADD;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) cur <= SIF;
        else       cur <= nxt;
    end

    always_comb begin
        nxt      = SIF;
        wpc_d    = 1'b0;
        wir_d    = 1'b0;
        wmem_d   = 1'b0;
        wreg_d   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        aluc     = ALU_ADD;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        sext     = 1'b0;
        pcsource = PC_ALU;
        jal      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = 1'b0;
`endif
        case (cur)
            SIF: begin
                wpc_d   = 1'b1;
                wir_d   = 1'b1;
                alusrcb = SRCB_FOUR;
                nxt     = SID;
            end
            // The ALU computes the branch target here while the IR is decoded
            SID: begin
                alusrcb = SRCB_BR;
                nxt     = SEXE;
                if (cls.i_j | cls.i_jal) begin
                    wpc_d    = 1'b1;
                    pcsource = PC_JUMP;
                    nxt      = SIF;
                end
                if (cls.i_jal) begin
                    wreg_d = 1'b1;
                    jal    = 1'b1;
                end
                if (cls.i_jr) begin
                    wpc_d    = 1'b1;
                    pcsource = PC_RS;
                    nxt      = SIF;
                end
`ifdef ILLEGAL_TRAP_EN
                if (cls.i_undef) begin
                    illegal_d = 1'b1;
                    nxt       = SIF;
                end
`endif
            end
            SEXE: begin
                nxt = SWB;
                if (r_alu) begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_REG;
                    aluc    = alu_op;
                    shift   = cls.i_sll | cls.i_srl | cls.i_sra;
                end
                if (is_imm) begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    aluc    = alu_op;
                    sext    = cls.i_addi | cls.i_lw | cls.i_sw;
                    if (cls.i_lw | cls.i_sw) nxt = SMEM;
                end
                if (cls.i_beq | cls.i_bne) begin
                    aluc     = ALU_SUB;
                    alusrca  = 1'b1;
                    alusrcb  = SRCB_REG;
                    sext     = 1'b1;
                    pcsource = PC_BR;
                    wpc_d    = (cls.i_beq & z) | (cls.i_bne & ~z);
                    nxt      = SIF;
                end
            end
            SMEM: begin
                iord   = 1'b1;
                wmem_d = cls.i_sw;
                nxt    = cls.i_lw ? SWB : SIF;
            end
            SWB: begin
                wreg_d = ~cls.i_undef;
                regrt  = wb_rt;
                m2reg  = cls.i_lw;
                nxt    = SIF;
            end
            default: nxt = SIF;
        endcase
    end

    // Write enables are gated by clrn so nothing commits while reset is held
    assign wpc   = wpc_d & clrn;
    assign wir   = wir_d & clrn;
    assign wmem  = wmem_d & clrn;
    assign wreg  = wreg_d & clrn;
    assign state = SW'(cur);

`ifdef ILLEGAL_TRAP_EN
    assign illegal = illegal_d;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mccu.sv
// Self-checking bench for mccu: per-cycle comparison against a behavioural model
// plus hand-computed literal checks. Honours ILLEGAL_TRAP_EN when defined.
module tb_mccu;

    typedef struct packed {
        logic       wpc, wir, wmem, wreg, iord, regrt, m2reg;
        logic [3:0] aluc;
        logic       shift, alusrca;
        logic [1:0] alusrcb;
        logic       sext;
        logic [1:0] pcsource;
        logic       jal;
        logic [2:0] state;
        logic       illegal;
    } ctl_t;

    logic       clk, clrn, z;
    logic [5:0] op, func;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, sext, jal, illegal;
    logic [3:0] aluc;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] state;
    ctl_t       act;

    int   tests_run = 0;
    int   tests_failed = 0;
    logic check_en = 1'b0;
    int   cur_step = 0;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mccu #(.SW(3)) dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .regrt(regrt), .m2reg(m2reg), .aluc(aluc), .shift(shift),
        .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext),
        .pcsource(pcsource), .jal(jal), .state(state), .illegal(illegal)
    );

    assign act = {wpc, wir, wmem, wreg, iord, regrt, m2reg, aluc, shift, alusrca,
                  alusrcb, sext, pcsource, jal, state, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level view: what each cycle of an instruction must drive
    function automatic ctl_t model(input logic [5:0] mop, input logic [5:0] mfn,
                                   input logic mz, input int step);
        ctl_t c;
        logic ralu, jr, imm, br, jmp, undef, lw, sw;
        c     = '0;
        ralu  = (mop == 6'h00) && (mfn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03});
        jr    = (mop == 6'h00) && (mfn == 6'h08);
        imm   = mop inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        br    = mop inside {6'h04, 6'h05};
        jmp   = mop inside {6'h02, 6'h03};
        undef = !(ralu || jr || imm || br || jmp);
        lw    = (mop == 6'h23);
        sw    = (mop == 6'h2B);
        if (step <= 2)            c.state = 3'(step);
        else if (step == 3 && (lw || sw)) c.state = 3'd3;
        else                      c.state = 3'd4;
        case (step)
            0: begin
                c.wpc = 1'b1; c.wir = 1'b1; c.alusrcb = 2'b01;
            end
            1: begin
                c.alusrcb = 2'b11;
                if (jmp) begin
                    c.wpc = 1'b1; c.pcsource = 2'b11;
                    c.jal = (mop == 6'h03); c.wreg = (mop == 6'h03);
                end
                if (jr) begin
                    c.wpc = 1'b1; c.pcsource = 2'b10;
                end
                c.illegal = TRAP && undef;
            end
            2: begin
                if (ralu) begin
                    c.alusrca = 1'b1;
                    c.shift   = mfn inside {6'h00, 6'h02, 6'h03};
                    case (mfn)
                        6'h22:   c.aluc = 4'b0100;
                        6'h24:   c.aluc = 4'b0001;
                        6'h25:   c.aluc = 4'b0101;
                        6'h26:   c.aluc = 4'b0010;
                        6'h00:   c.aluc = 4'b0011;
                        6'h02:   c.aluc = 4'b0111;
                        6'h03:   c.aluc = 4'b1111;
                        default: c.aluc = 4'b0000;
                    endcase
                end
                if (imm) begin
                    c.alusrca = 1'b1; c.alusrcb = 2'b10;
                    c.sext    = mop inside {6'h08, 6'h23, 6'h2B};
                    case (mop)
                        6'h0C:   c.aluc = 4'b0001;
                        6'h0D:   c.aluc = 4'b0101;
                        6'h0E:   c.aluc = 4'b0010;
                        6'h0F:   c.aluc = 4'b0110;
                        default: c.aluc = 4'b0000;
                    endcase
                end
                if (br) begin
                    c.aluc = 4'b0100; c.alusrca = 1'b1; c.sext = 1'b1; c.pcsource = 2'b01;
                    c.wpc  = (mop == 6'h04) ? mz : !mz;
                end
            end
            default: begin
                if (step == 3 && (lw || sw)) begin
                    c.iord = 1'b1; c.wmem = sw;
                end else begin
                    c.wreg = !undef; c.regrt = imm && !sw; c.m2reg = lw;
                end
            end
        endcase
        return c;
    endfunction

    function automatic int cpi_of(input logic [5:0] mop, input logic [5:0] mfn);
        logic known;
        known = (mop == 6'h00) ? (mfn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08})
                               : (mop inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                                              6'h0E, 6'h0F, 6'h23, 6'h2B});
        if (!known)                                   return TRAP ? 2 : 4;
        if (mop inside {6'h02, 6'h03})                return 2;
        if (mop == 6'h00 && mfn == 6'h08)             return 2;
        if (mop inside {6'h04, 6'h05})                return 3;
        if (mop == 6'h23)                             return 5;
        return 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s (op=%h func=%h step=%0d): got %h, expected %h",
                     name, op, func, cur_step, got, exp);
        end
    endtask

    // Runs one whole instruction; z is randomised outside SEXE since it must be ignored there
    task automatic applyStimulus(input logic [5:0] sop, input logic [5:0] sfn, input logic zv);
        int n;
        n    = cpi_of(sop, sfn);
        op   = sop;
        func = sfn;
        for (int s = 0; s < n; s++) begin
            cur_step = s;
            z        = (s == 2) ? zv : 1'($urandom_range(0, 1));
            check_en = 1'b1;
            @(posedge clk);
            #1;
        end
        check_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput("model", 32'(act), 32'(model(op, func, z, cur_step)));
    end

    localparam int NVEC = 26;
    logic [12:0] vec [NVEC] = '{
        {6'h00, 6'h20, 1'b0}, {6'h00, 6'h22, 1'b1}, {6'h00, 6'h24, 1'b0}, {6'h00, 6'h25, 1'b0},
        {6'h00, 6'h26, 1'b1}, {6'h00, 6'h00, 1'b0}, {6'h00, 6'h02, 1'b0}, {6'h00, 6'h03, 1'b1},
        {6'h00, 6'h08, 1'b0}, {6'h08, 6'h15, 1'b0}, {6'h0C, 6'h3F, 1'b1}, {6'h0D, 6'h00, 1'b0},
        {6'h0E, 6'h11, 1'b0}, {6'h0F, 6'h00, 1'b1}, {6'h23, 6'h00, 1'b0}, {6'h2B, 6'h00, 1'b1},
        {6'h04, 6'h00, 1'b1}, {6'h04, 6'h00, 1'b0}, {6'h05, 6'h00, 1'b1}, {6'h05, 6'h00, 1'b0},
        {6'h02, 6'h00, 1'b0}, {6'h03, 6'h00, 1'b1}, {6'h3F, 6'h00, 1'b0}, {6'h00, 6'h3F, 1'b0},
        {6'h00, 6'h20, 1'b1}, {6'h23, 6'h00, 1'b1}
    };

    logic [7:0] br_vec [4] = '{
        {6'h04, 1'b1, 1'b1}, {6'h04, 1'b0, 1'b0}, {6'h05, 1'b1, 1'b0}, {6'h05, 1'b0, 1'b1}
    };

    initial begin
        clrn = 1'b1; op = 6'h00; func = 6'h00; z = 1'b0;
        #1 clrn = 1'b0;
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_writes", 32'({wpc, wir, wmem, wreg}), 32'd0);
        checkOutput("reset_alusrcb", 32'(alusrcb), 32'd1);
        repeat (2) @(posedge clk);
        #1 clrn = 1'b1;

        for (int i = 0; i < NVEC; i++) applyStimulus(vec[i][12:7], vec[i][6:1], vec[i][0]);

        // lw walked by hand: five cycles
        op = 6'h23; func = 6'h00;
        @(negedge clk); checkOutput("lw_if_state", 32'(state), 32'd0);
        checkOutput("lw_if_wir", 32'(wir), 32'd1);
        @(negedge clk); checkOutput("lw_id_state", 32'(state), 32'd1);
        @(negedge clk); checkOutput("lw_exe_srcb_sext", 32'({alusrcb, sext}), 32'b101);
        @(negedge clk); checkOutput("lw_mem_state", 32'(state), 32'd3);
        checkOutput("lw_mem_iord_wmem", 32'({iord, wmem}), 32'b10);
        @(negedge clk); checkOutput("lw_wb_state", 32'(state), 32'd4);
        checkOutput("lw_wb_ctrl", 32'({wreg, regrt, m2reg}), 32'b111);
        @(negedge clk); checkOutput("lw_next_state", 32'(state), 32'd0);

        // sra: shift with arithmetic aluc
        op = 6'h00; func = 6'h03;
        @(negedge clk);
        @(negedge clk); checkOutput("sra_aluc", 32'(aluc), 32'hF);
        checkOutput("sra_shift", 32'(shift), 32'd1);
        @(negedge clk); checkOutput("sra_wb", 32'({state, wreg, regrt}), 32'b100_1_0);
        @(negedge clk);

        // jal completes in two cycles
        op = 6'h03; func = 6'h00;
        @(negedge clk); checkOutput("jal_id_writes", 32'({wpc, wreg, jal}), 32'b111);
        checkOutput("jal_pcsource", 32'(pcsource), 32'd3);
        @(negedge clk); checkOutput("jal_next_state", 32'(state), 32'd0);

        for (int i = 0; i < 4; i++) begin
            op = br_vec[i][7:2]; func = 6'h00;
            @(negedge clk);
            z = br_vec[i][1];
            @(negedge clk); checkOutput("branch_wpc", 32'(wpc), 32'(br_vec[i][0]));
            checkOutput("branch_pcsource", 32'(pcsource), 32'd1);
            @(negedge clk); checkOutput("branch_next_state", 32'(state), 32'd0);
        end

        // Undefined opcode: trap or 4-cycle NOP
        op = 6'h3F; func = 6'h00;
        @(negedge clk); checkOutput("undef_illegal", 32'(illegal), 32'(TRAP));
        checkOutput("undef_id_writes", 32'({wpc, wir, wmem, wreg}), 32'd0);
        @(negedge clk); checkOutput("undef_after_id", 32'(state), TRAP ? 32'd0 : 32'd2);
        if (!TRAP) begin
            @(negedge clk); checkOutput("undef_wb_wreg", 32'({state, wreg}), 32'b100_0);
            @(negedge clk); checkOutput("undef_end_state", 32'(state), 32'd0);
        end

        // Reset asserted in the middle of sw's memory cycle
        op = 6'h2B; func = 6'h00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); checkOutput("sw_mem_wmem", 32'({state, wmem}), 32'b011_1);
        #1 clrn = 1'b0;
        #1;
        checkOutput("midreset_state", 32'(state), 32'd0);
        checkOutput("midreset_writes", 32'({wpc, wir, wmem, wreg}), 32'd0);
        @(posedge clk);
        #1 clrn = 1'b1;
        @(negedge clk); checkOutput("post_reset_state0", 32'(state), 32'd0);
        @(negedge clk); checkOutput("post_reset_state1", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mccu.md
Name: mccu

Overview:
- Multi-cycle control unit for the single-ALU MIPS-subset CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB states, time-sharing the one 32-bit ALU between PC increment, branch-target computation and execute.
- Drives ALU opcode, operand muxes, memory/register/PC write enables and PC source from the current state, opcode/func and the ALU zero flag.

Parameters:
- SW, 3, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- op  in  6  instruction[31:26] from IR.
- func  in  6  instruction[5:0] from IR.
- z  in  1  ALU zero flag (combinational, same cycle).
- wpc  out  1  PC write enable.
- wir  out  1  IR write enable.
- wmem  out  1  data memory write enable.
- wreg  out  1  register file write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- regrt  out  1  destination select: 0 = rd, 1 = rt.
- m2reg  out  1  writeback select: 1 = memory data register.
- aluc  out  4  ALU operation code.
- shift  out  1  ALU A operand = sa (zero-extended instr[10:6]).
- alusrca  out  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B: 00 = reg B, 01 = 4, 10 = ext imm, 11 = sext imm<<2.
- sext  out  1  immediate sign-extend (1) vs zero-extend (0).
- pcsource  out  2  00 = ALU, 01 = branch target reg, 10 = rs, 11 = jump addr.
- jal  out  1  write PC+4 to r31.
- state  out  SW  current state, debug.
- illegal  out  1  undefined instruction flag.

Behaviour:
- Single clock domain. clrn is asynchronous and active-low; it forces state = SIF immediately.
- While clrn = 0, wpc, wir, wmem and wreg are forced to 0. All other outputs take their SIF decode.
- State encodings: SIF = 0, SID = 1, SEXE = 2, SMEM = 3, SWB = 4. Codes 5–7 return to SIF on the next clock, with all write enables 0.
- aluc codes: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- Outputs are decoded combinationally from state, op, func and z. Unlisted outputs are 0.
- SIF:
  - wpc = wir = 1, iord = 0, alusrca = 0, alusrcb = 01, aluc = add, pcsource = 00.
  - Next state: SID.
- SID:
  - alusrca = 0, alusrcb = 11, aluc = add (branch target latched externally).
  - j: wpc = 1, pcsource = 11.
  - jal: wpc = 1, pcsource = 11, wreg = 1, jal = 1.
  - jr: wpc = 1, pcsource = 10.
  - Next state: SIF for j/jal/jr, else SEXE.
- SEXE:
  - R-type ALU ops: alusrca = 1, alusrcb = 00, aluc per func. sll/srl/sra additionally set shift = 1.
  - Immediates: alusrca = 1, alusrcb = 10. sext = 1 for addi/lw/sw/beq/bne, 0 for andi/ori/xori. lui uses aluc = lui.
  - beq/bne: aluc = sub, alusrca = 1, alusrcb = 00, pcsource = 01, wpc = (beq & z) | (bne & ~z).
  - Next state: SIF for beq/bne, SMEM for lw/sw, else SWB.
- SMEM:
  - iord = 1. sw: wmem = 1.
  - Next state: SWB for lw, SIF for sw.
- SWB:
  - wreg = 1. regrt = 1 for I-type. m2reg = 1 for lw.
  - Next state: SIF.
- Cycles per instruction: j/jal/jr 2, beq/bne 3, R-type/immediate/sw 4, lw 5.
- z is sampled only in SEXE; its value in all other states is ignored.
- Reset mid-instruction abandons the instruction with no partial write after clrn falls.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undefined op/func in SID asserts illegal for that cycle, suppresses all writes and returns to SIF. Any R-type func outside the supported set is also illegal.
- Undefined: illegal is tied 0. An undefined instruction proceeds SID -> SEXE -> SWB with wreg = 0, i.e. a 4-cycle NOP.

Decomposition:
- Shared package mccu_pkg: state codes, opcode/func constants, aluc constants, alusrcb/pcsource select constants.
- One sub-module, mccu_decode: combinational op/func -> one-hot instruction class (i_add … i_jal, i_rtype, i_undef). The FSM and output decode stay in mccu.

Test Plan:
- Reset: clrn low mid-SMEM of sw -> state = 0 immediately, wmem = 0; after release, state sequence 0, 1.
- add (op 0, func 0x20) -> states 0, 1, 2, 4, 0; in SEXE aluc = 0000, alusrca = 1, alusrcb = 00; in SWB wreg = 1, regrt = 0.
- lw (op 0x23) -> 5 cycles; SMEM iord = 1; SWB m2reg = 1, regrt = 1. sw (op 0x2B) -> 4 cycles, wmem = 1 in SMEM only.
- beq (op 0x04) with z = 1 -> SEXE wpc = 1, pcsource = 01. With z = 0 -> wpc = 0. bne inverts both cases.
- jal (op 0x03) -> SID wpc = 1, wreg = 1, jal = 1, pcsource = 11; next state 0. sra (func 0x03) -> aluc = 1111, shift = 1.
- ILLEGAL_TRAP_EN defined, op = 0x3F -> illegal = 1 in SID, no writes, next state SIF. Macro undefined -> illegal = 0, 4-cycle NOP.
